clb_cfg_loader: RTL

Serial configuration loader for a column of clb39-style logic blocks. It hunts a preamble on a 1-bit bitstream and shifts in one 37-bit configuration frame per CLB. Each frame is checked with a parity bit and a stop bit, then written to the addressed CLB's configuration register. It sits between the device bitstream pin logic and the CLB array and sequences the whole array's programming.

---
 rtl/clb_cfg_pkg.sv | 47 ++++
 rtl/clb_cfg_shift.sv | 40 ++++
 rtl/clb_cfg_loader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/clb_cfg_pkg.sv
// Shared constants for the CLB column configuration loader: frame width,
// preamble, payload field layout, FSM states and the default clb39 frame.
package clb_cfg_pkg;

  localparam int CFG_W = 37;

  // Marks the start of every frame in the serial bitstream.
  localparam logic [3:0] PREAMBLE = 4'b0010;

  // Payload field layout (LSB position and width of each field).
  localparam int MUXSEL_W  = 2;
  localparam int MUX2_LSB  = 35;
  localparam int MUX3_LSB  = 33;
  localparam int MUX4_LSB  = 31;
  localparam int MUX5_LSB  = 29;
  localparam int MUX6_LSB  = 27;
  localparam int MEM_LSB   = 11;
  localparam int MEM_W     = 16;
  localparam int COMBO_LSB = 9;
  localparam int COMBO_W   = 2;
  localparam int O2M_LSB   = 3;
  localparam int O2M_W     = 6;
  localparam int DQMUX_LSB = 1;
  localparam int DQMUX_W   = 2;
  localparam int FLOP_BIT  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HUNT,
    ST_LOAD,
    ST_PAR,
    ST_STOP,
    ST_FIN,
    ST_ERROR
  } state_e;

  // Power-on clb39 configuration.
  localparam logic [CFG_W-1:0] CLB_CFG_DEFAULT = {
    2'b10, 2'b10, 2'b10, 2'b00, 2'b00,  // mux2..mux6 selects
    16'h0116,                           // LUT contents
    2'b00,                              // comboption
    6'b000111,                          // o2m selects
    2'b00,                              // DQmux1, DQmux2
    1'b0                                // floporlatch
  };

endpackage

// File: rtl/clb_cfg_shift.sv
// Payload shift register for one configuration frame: collects W bits MSB
// first, counts them and keeps the running XOR for the parity check.
module clb_cfg_shift
  import clb_cfg_pkg::*;
#(
  parameter int W = CFG_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         din,
  output logic [W-1:0] payload,
  output logic         full,
  output logic         parity
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt;

  // Shift one bit in, count it and fold it into the parity.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the
    // values present before the edge, independent of statement order.
    if (rst || clr) begin
      payload <= '0;
      cnt     <= '0;
      parity  <= 1'b0;
    end else if (shift_en) begin
      payload <= {payload[W-2:0], din};
      cnt     <= cnt + CW'(1);
      parity  <= parity ^ din;
    end
  end

  // High while the next shift completes the frame.
  assign full = (cnt == CW'(W - 1));

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial configuration loader for a column of clb39 logic blocks. Hunts the
// preamble, loads a frame, checks parity and stop bit, then writes the frame
// to the addressed CLB. Repeats for NFRAMES frames per PROG sequence.
module clb_cfg_loader #(
  parameter int NFRAMES = 4,
  parameter int AW      = 2,
  parameter int CFG_W   = 37
) (
  input  logic             K,
  input  logic             RST,
  input  logic             PROG,
  input  logic             DIN,
  input  logic             DVAL,
  output logic [CFG_W-1:0] CFG_OUT,
  output logic [AW-1:0]    CFG_ADDR,
  output logic             CFG_WE,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  import clb_cfg_pkg::*;

  state_e           state, state_nxt;
  // Last three bits seen in HUNT; the live DIN completes the 4-bit window.
  logic [2:0]       window;
  logic [AW-1:0]    frame_cnt;
  logic [CFG_W-1:0] payload;
  logic             full, parity;
  logic [CFG_W-1:0] cfg_out;
  logic [AW-1:0]    cfg_addr;
  logic             cfg_we;

  logic sh_clr, sh_en, win_clr, win_shift, frame_clr, frame_inc, do_write;
  logic last_frame;

  assign last_frame = (frame_cnt == AW'(NFRAMES - 1));

  clb_cfg_shift #(.W(CFG_W)) u_shift (
    .clk      (K),
    .rst      (RST),
    .clr      (sh_clr),
    .shift_en (sh_en),
    .din      (DIN),
    .payload  (payload),
    .full     (full),
    .parity   (parity)
  );

  // State register.
  always_ff @(posedge K) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath control; PROG restarts from any state.
  always_comb begin
    // NOTE: every output gets a default first, so no branch leaves one
    // unassigned and no latch is inferred.
    state_nxt = state;
    sh_clr    = 1'b0;
    sh_en     = 1'b0;
    win_clr   = 1'b0;
    win_shift = 1'b0;
    frame_clr = 1'b0;
    frame_inc = 1'b0;
    do_write  = 1'b0;
    if (PROG) begin
      state_nxt = ST_HUNT;
      win_clr   = 1'b1;
      frame_clr = 1'b1;
      sh_clr    = 1'b1;
    end else if (DVAL) begin
      case (state)
        ST_HUNT: begin
          if ({window, DIN} == PREAMBLE) begin
            state_nxt = ST_LOAD;
            sh_clr    = 1'b1;
            // Start the next frame's hunt from a clean window.
            win_clr   = 1'b1;
          end else begin
            win_shift = 1'b1;
          end
        end
        ST_LOAD: begin
          sh_en = 1'b1;
          if (full) state_nxt = ST_PAR;
        end
        ST_PAR: begin
          state_nxt = (parity ^ DIN) ? ST_ERROR : ST_STOP;
        end
        ST_STOP: begin
          if (!DIN) begin
            state_nxt = ST_ERROR;
          end else begin
            do_write = 1'b1;
            if (last_frame) begin
              state_nxt = ST_FIN;
            end else begin
              frame_inc = 1'b1;
              state_nxt = ST_HUNT;
            end
          end
        end
        default: ;  // IDLE, FIN and ERROR ignore DIN
      endcase
    end
  end

  // Preamble window, frame counter and the registered write port.
  always_ff @(posedge K) begin
    if (RST) begin
      window    <= '0;
      frame_cnt <= '0;
      cfg_out   <= '0;
      cfg_addr  <= '0;
      cfg_we    <= 1'b0;
    end else begin
      if (win_clr)        window <= '0;
      else if (win_shift) window <= {window[1:0], DIN};

      if (frame_clr)      frame_cnt <= '0;
      else if (frame_inc) frame_cnt <= frame_cnt + AW'(1);

      cfg_we <= do_write;
      if (do_write) begin
        cfg_out  <= payload;
        cfg_addr <= frame_cnt;
      end
    end
  end

  assign CFG_OUT  = cfg_out;
  assign CFG_ADDR = cfg_addr;
  assign CFG_WE   = cfg_we;
  assign BUSY     = (state == ST_HUNT) || (state == ST_LOAD) ||
                    (state == ST_PAR)  || (state == ST_STOP);
  assign DONE     = (state == ST_FIN);
  assign ERR      = (state == ST_ERROR);

endmodule
